// File: rtl/gs_sobel3x3.sv
// ---------------------------------------------------------------------------
// gs_sobel3x3
//   Sobel edge detector for the grayscale pixel stream coming out of the 2x2
//   Bayer-average stage. Two line buffers hold the previous two rows. Together
//   with the live pixel they form a 3x3 window that the Sobel kernel runs over.
//   Each pixel accepted from input row 2 onward produces one edge-magnitude
//   pixel. The result goes to the SDRAM write-side formatter.
//
// Ports
//   clk         in   1      pixel clock
//   rst_n       in   1      asynchronous, active-low reset
//   sof         in   1      start of frame, qualified by gs_valid, marks (0,0)
//   gs_valid    in   1      input pixel strobe, gaps allowed
//   gs_data     in   PIX_W  grayscale pixel, unsigned
//   mode        in   2      0:|Gx| 1:|Gy| 2:|Gx|+|Gy| 3:centre pass-through
//   out_valid   out  1      output pixel strobe (registered)
//   out_data    out  PIX_W  edge magnitude, unsigned, saturated (registered)
//   frame_done  out  1      pulse together with the last output of a frame
//   busy        out  1      high from accepted sof until after frame_done
//
// Pipeline
//   edge A   : pixel accepted, line buffers read/written, window shifted
//   edge A+1 : kernel, absolute value and saturation registered
//   edge A+2 : output registers, so out_valid rises two clocks after A
// ---------------------------------------------------------------------------
module gs_sobel3x3 #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int PIX_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sof,
    input  logic             gs_valid,
    input  logic [PIX_W-1:0] gs_data,
    input  logic [1:0]       mode,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_data,
    output logic             frame_done,
    output logic             busy
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    // Gradient width: signed PIX_W+3 bits, because 4*max fits with a sign bit
    localparam int GW = PIX_W + 3;

    localparam logic [CW-1:0]    COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0]    ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0]    COL_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    COL_TWO  = CW'(2);
    localparam logic [RW-1:0]    ROW_ONE  = {{(RW-1){1'b0}}, 1'b1};
    localparam logic [GW-1:0]    G_ONE    = {{(GW-1){1'b0}}, 1'b1};
    localparam logic [PIX_W-1:0] PIX_MAX  = {PIX_W{1'b1}};
    localparam logic [PIX_W-1:0] PIX_ZERO = {PIX_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Two's-complement magnitude. The input never reaches the most negative
    // code, so the result always fits in GW bits.
    function automatic logic [GW-1:0] abs_f(input logic signed [GW-1:0] v);
        logic [GW-1:0] r;
        if (v[GW-1]) begin
            r = ~v + G_ONE;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Clamp a PIX_W+4 bit magnitude to the PIX_W output range
    function automatic logic [PIX_W-1:0] sat_f(input logic [GW:0] v);
        logic [PIX_W-1:0] r;
        if (v > {4'b0000, PIX_MAX}) begin
            r = PIX_MAX;
        end else begin
            r = v[PIX_W-1:0];
        end
        return r;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CW-1:0]    col_r;
    logic [RW-1:0]    row_r;
    logic [1:0]       mode_q_r;

    logic             start_s;
    logic             accept_s;
    logic             emit_s;
    logic             col_last_s;
    logic             row_last_s;
    logic             last_s;
    logic [CW-1:0]    pix_col_s;

    logic [PIX_W-1:0] lb0_r [IMG_W];
    logic [PIX_W-1:0] lb1_r [IMG_W];
    logic [PIX_W-1:0] win_r [3][3];

    logic             v1_r;
    logic             border1_r;
    logic             last1_r;
    logic [1:0]       mode1_r;

    logic [GW-1:0]    gx_pos_s;
    logic [GW-1:0]    gx_neg_s;
    logic [GW-1:0]    gy_pos_s;
    logic [GW-1:0]    gy_neg_s;
    logic [GW-1:0]    gx_s;
    logic [GW-1:0]    gy_s;
    logic [GW-1:0]    ax_s;
    logic [GW-1:0]    ay_s;
    logic [GW:0]      sum_s;
    logic [PIX_W-1:0] res_s;

    logic             v2_r;
    logic             last2_r;
    logic [PIX_W-1:0] res2_r;

    // A qualified sof is pixel (0,0) in every state. Otherwise pixels count
    // only while a frame is open.
    assign start_s    = gs_valid & sof;
    assign accept_s   = gs_valid & (sof | (state_r != ST_IDLE));
    assign col_last_s = (col_r == COL_LAST);
    assign row_last_s = (row_r == ROW_LAST);
    assign emit_s     = gs_valid & ~sof & (state_r == ST_RUN);
    assign last_s     = emit_s & col_last_s & row_last_s;
    // Column that the accepted pixel occupies. A restart forces column 0.
    assign pix_col_s  = start_s ? {CW{1'b0}} : col_r;

    // Frame-state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic. sof takes priority and restarts the frame from any state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = ST_FILL;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (start_s) begin
                    state_nxt_s = ST_FILL;
                end else if (gs_valid && col_last_s && (row_r == ROW_ONE)) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_RUN: begin
                if (start_s) begin
                    state_nxt_s = ST_FILL;
                end else if (last_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Column/row counters: position of the next pixel expected
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r <= {CW{1'b0}};
            row_r <= {RW{1'b0}};
        end else if (start_s) begin
            // (0,0) is consumed on this cycle, so the next pixel is (0,1)
            col_r <= COL_ONE;
            row_r <= {RW{1'b0}};
        end else if (accept_s) begin
            if (col_last_s) begin
                col_r <= {CW{1'b0}};
                row_r <= row_last_s ? {RW{1'b0}} : (row_r + ROW_ONE);
            end else begin
                col_r <= col_r + COL_ONE;
            end
        end
    end

    // Mode is sampled only at frame start, so a mid-frame change has no effect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q_r <= 2'd0;
        end else if (start_s) begin
            mode_q_r <= mode;
        end
    end

    // Line buffers: read-before-write at the same column. lb0 holds row-1 and
    // lb1 holds row-2. The storage is not reset because rows are overwritten
    // before they are used.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb0_r[pix_col_s] <= gs_data;
            lb1_r[pix_col_s] <= lb0_r[pix_col_s];
        end
    end

    // Window shift: the new right column is {row-2, row-1, row} at this column
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_r[r][c] <= PIX_ZERO;
                end
            end
        end else if (accept_s) begin
            for (int r = 0; r < 3; r++) begin
                win_r[r][0] <= win_r[r][1];
                win_r[r][1] <= win_r[r][2];
            end
            win_r[0][2] <= lb1_r[pix_col_s];
            win_r[1][2] <= lb0_r[pix_col_s];
            win_r[2][2] <= gs_data;
        end
    end

    // Stage-1 side-band: this pixel's output strobe, border flag, last-pixel flag and mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r      <= 1'b0;
            border1_r <= 1'b0;
            last1_r   <= 1'b0;
            mode1_r   <= 2'd0;
        end else begin
            v1_r      <= emit_s;
            border1_r <= (pix_col_s < COL_TWO);
            last1_r   <= last_s;
            mode1_r   <= mode_q_r;
        end
    end

    // Sobel kernel on the window. Each weighted sum is non-negative, so the
    // two sums are built unsigned and subtracted as signed values.
    always_comb begin
        gx_pos_s = {3'b000, win_r[0][2]} + {2'b00, win_r[1][2], 1'b0} + {3'b000, win_r[2][2]};
        gx_neg_s = {3'b000, win_r[0][0]} + {2'b00, win_r[1][0], 1'b0} + {3'b000, win_r[2][0]};
        gy_pos_s = {3'b000, win_r[2][0]} + {2'b00, win_r[2][1], 1'b0} + {3'b000, win_r[2][2]};
        gy_neg_s = {3'b000, win_r[0][0]} + {2'b00, win_r[0][1], 1'b0} + {3'b000, win_r[0][2]};
        gx_s     = gx_pos_s - gx_neg_s;
        gy_s     = gy_pos_s - gy_neg_s;
        ax_s     = abs_f(gx_s);
        ay_s     = abs_f(gy_s);
        sum_s    = {1'b0, ax_s} + {1'b0, ay_s};
    end

    // Mode select and border blanking. Outputs with fewer than three valid
    // columns in the window are forced to zero.
    always_comb begin
        res_s = PIX_ZERO;
        if (border1_r) begin
            res_s = PIX_ZERO;
        end else begin
            case (mode1_r)
                2'd0:    res_s = sat_f({1'b0, ax_s});
                2'd1:    res_s = sat_f({1'b0, ay_s});
                2'd2:    res_s = sat_f(sum_s);
                2'd3:    res_s = win_r[1][1];
                default: res_s = PIX_ZERO;
            endcase
        end
    end

    // Stage-2 register: kernel result and its strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_r    <= 1'b0;
            last2_r <= 1'b0;
            res2_r  <= PIX_ZERO;
        end else begin
            v2_r    <= v1_r;
            last2_r <= v1_r & last1_r;
            res2_r  <= v1_r ? res_s : PIX_ZERO;
        end
    end

    // Output register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= PIX_ZERO;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= v2_r;
            out_data   <= res2_r;
            frame_done <= last2_r;
        end
    end

    // busy rises with an accepted sof and clears one cycle after frame_done.
    // A frame that has already restarted keeps it high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
        end else if (start_s) begin
            busy <= 1'b1;
        end else if (frame_done && (state_r == ST_IDLE)) begin
            busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gs_sobel3x3.sv
module tb_gs_sobel3x3;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int PW = 12;

    logic          clk;
    logic          rst_n;
    logic          sof;
    logic          gs_valid;
    logic [PW-1:0] gs_data;
    logic [1:0]    mode;
    logic          out_valid;
    logic [PW-1:0] out_data;
    logic          frame_done;
    logic          busy;

    gs_sobel3x3 #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sof        (sof),
        .gs_valid   (gs_valid),
        .gs_data    (gs_data),
        .mode       (mode),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .frame_done (frame_done),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [PW-1:0] val;
        logic          fd;
        int            due;
    } exp_t;

    exp_t          q[$];
    logic [PW-1:0] cap[$];
    int            fd_cnt = 0;
    logic [PW-1:0] img [H][W];
    bit            act = 0;
    int            rr = 0;
    int            rc = 0;
    logic [1:0]    rmode = 2'd0;
    bit            exp_busy = 0;
    int            bset = -1;
    int            bclr = -1;

    // Sobel output for input pixel (r,c): centre is (r-1,c-1); columns 0,1 blank
    function automatic logic [PW-1:0] ref_pix(input int r, input int c, input logic [1:0] m);
        int a [3][3];
        int gx, gy, res;
        if (c < 2) return '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                a[i][j] = int'(img[r-2+i][c-2+j]);
        gx = (a[0][2] + 2*a[1][2] + a[2][2]) - (a[0][0] + 2*a[1][0] + a[2][0]);
        gy = (a[2][0] + 2*a[2][1] + a[2][2]) - (a[0][0] + 2*a[0][1] + a[0][2]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        case (m)
            2'd0:    res = gx;
            2'd1:    res = gy;
            2'd2:    res = gx + gy;
            default: res = a[1][1];
        endcase
        if (res > 4095) res = 4095;
        return PW'(res);
    endfunction

    // Apply one cycle of inputs (set #1 after a posedge, accepted at the next
    // posedge) and update the model
    task automatic drive(input logic v, input logic s, input logic [PW-1:0] d, input logic [1:0] m);
        exp_t e;
        gs_valid = v;
        sof      = s;
        gs_data  = d;
        mode     = m;
        if (v) begin
            if (s) begin
                act   = 1;
                rr    = 0;
                rc    = 0;
                rmode = m;
                bset  = edge_cnt + 1;
                bclr  = -1;
            end
            if (act) begin
                img[rr][rc] = d;
                if (rr >= 2) begin
                    e.val = ref_pix(rr, rc, rmode);
                    e.fd  = (rr == H-1) && (rc == W-1);
                    e.due = edge_cnt + 3;
                    q.push_back(e);
                end
                if ((rr == H-1) && (rc == W-1)) begin
                    act  = 0;
                    bclr = edge_cnt + 4;
                end
                rc++;
                if (rc == W) begin
                    rc = 0;
                    rr++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 12'($urandom_range(4095)), 2'($urandom_range(3)));
    endtask

    // kind 0: left/right split at column W/2; kind 1: random pixels
    task automatic send_frame(input logic [1:0] m, input int kind, input int lv, input int rv,
                              input int gap, input int npix);
        int r, c;
        logic [PW-1:0] d;
        logic [1:0] md;
        for (int i = 0; i < npix; i++) begin
            r = i / W;
            c = i % W;
            while ($urandom_range(99) < gap) idle(1);
            if (kind == 0) d = (c < W/2) ? PW'(lv) : PW'(rv);
            else           d = 12'($urandom_range(4095));
            // mode changes inside a frame must be ignored
            md = (i == 0) ? m : 2'($urandom_range(3));
            drive(1'b1, (i == 0), d, md);
        end
    endtask

    // Output monitor: every cycle, compare against the scheduled expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (edge_cnt == bset) exp_busy = 1;
            if (edge_cnt == bclr) exp_busy = 0;
            chk("busy", 32'(busy), 32'(exp_busy));
            if (q.size() > 0 && q[0].due == edge_cnt) begin
                e = q.pop_front();
                chk("out_valid", 32'(out_valid), 32'd1);
                chk("out_data", 32'(out_data), 32'(e.val));
                chk("frame_done", 32'(frame_done), 32'(e.fd));
            end else begin
                chk("out_valid_idle", 32'(out_valid), 32'd0);
                chk("frame_done_idle", 32'(frame_done), 32'd0);
            end
            if (out_valid) cap.push_back(out_data);
            if (frame_done) fd_cnt++;
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic [1:0]            mode;
        logic [PW-1:0]         lv;
        logic [PW-1:0]         rv;
        logic [W-1:0][PW-1:0]  exp_row;   // expected value per input column
    } vec_t;

    vec_t tbl [7];

    initial begin
        tbl[0] = '{mode: 2'd2, lv: 12'd100,  rv: 12'd100,  exp_row: {12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0}};
        tbl[1] = '{mode: 2'd0, lv: 12'd0,    rv: 12'd1000, exp_row: {12'd0, 12'd0, 12'd4000, 12'd4000, 12'd0, 12'd0, 12'd0, 12'd0}};
        tbl[2] = '{mode: 2'd1, lv: 12'd0,    rv: 12'd1000, exp_row: {12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0}};
        tbl[3] = '{mode: 2'd2, lv: 12'd0,    rv: 12'd4095, exp_row: {12'd0, 12'd0, 12'd4095, 12'd4095, 12'd0, 12'd0, 12'd0, 12'd0}};
        tbl[4] = '{mode: 2'd0, lv: 12'd4095, rv: 12'd0,    exp_row: {12'd0, 12'd0, 12'd4095, 12'd4095, 12'd0, 12'd0, 12'd0, 12'd0}};
        tbl[5] = '{mode: 2'd3, lv: 12'd0,    rv: 12'd1000, exp_row: {12'd1000, 12'd1000, 12'd1000, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0}};
        tbl[6] = '{mode: 2'd2, lv: 12'd0,    rv: 12'd1000, exp_row: {12'd0, 12'd0, 12'd4000, 12'd4000, 12'd0, 12'd0, 12'd0, 12'd0}};

        rst_n    = 1'b0;
        sof      = 1'b0;
        gs_valid = 1'b0;
        gs_data  = '0;
        mode     = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Table-driven frames
        for (int t = 0; t < 7; t++) begin
            cap.delete();
            fd_cnt = 0;
            send_frame(tbl[t].mode, 0, int'(tbl[t].lv), int'(tbl[t].rv), 0, W*H);
            idle(6);
            chk($sformatf("vec%0d_count", t), 32'(cap.size()), 32'(W*(H-2)));
            for (int j = 0; j < cap.size() && j < W*(H-2); j++)
                chk($sformatf("vec%0d_pix%0d", t, j), 32'(cap[j]), 32'(tbl[t].exp_row[j % W]));
            chk($sformatf("vec%0d_fd", t), 32'(fd_cnt), 32'd1);
        end

        // gs_valid in IDLE and sof without gs_valid are both ignored
        cap.delete();
        drive(1'b1, 1'b0, 12'd500, 2'd2);
        drive(1'b0, 1'b1, 12'd600, 2'd2);
        drive(1'b1, 1'b0, 12'd700, 2'd2);
        idle(5);
        chk("idle_no_output", 32'(cap.size()), 32'd0);

        // Random frames with 50% valid gaps, all modes
        for (int m = 0; m < 4; m++) begin
            cap.delete();
            fd_cnt = 0;
            send_frame(2'(m), 1, 0, 0, 50, W*H);
            idle(6);
            chk("rand_count", 32'(cap.size()), 32'(W*(H-2)));
            chk("rand_fd", 32'(fd_cnt), 32'd1);
        end

        // sof at pixel (1,3) of frame A restarts frame B: A gives no frame_done
        cap.delete();
        fd_cnt = 0;
        send_frame(2'd2, 1, 0, 0, 0, W + 3);
        send_frame(2'd0, 1, 0, 0, 20, W*H);
        idle(6);
        chk("restart_fill_count", 32'(cap.size()), 32'(W*(H-2)));
        chk("restart_fill_fd", 32'(fd_cnt), 32'd1);

        // sof in RUN: in-flight outputs of A still emit
        cap.delete();
        fd_cnt = 0;
        send_frame(2'd1, 1, 0, 0, 0, 2*W + 3);
        send_frame(2'd2, 1, 0, 0, 0, W*H);
        idle(6);
        chk("restart_run_count", 32'(cap.size()), 32'(3 + W*(H-2)));
        chk("restart_run_fd", 32'(fd_cnt), 32'd1);

        // Reset in the middle of RUN, then a fresh frame
        send_frame(2'd2, 1, 0, 0, 0, 2*W + 5);
        rst_n = 1'b0;
        q.delete();
        act      = 0;
        exp_busy = 0;
        bset     = -1;
        bclr     = -1;
        idle(3);
        rst_n = 1'b1;
        idle(2);
        cap.delete();
        fd_cnt = 0;
        send_frame(2'd2, 1, 0, 0, 30, W*H);
        idle(6);
        chk("post_reset_count", 32'(cap.size()), 32'(W*(H-2)));
        chk("post_reset_fd", 32'(fd_cnt), 32'd1);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
